// File: rtl/display_frame_streamer.sv
// display_frame_streamer
//   Streams a 16-bit-per-pixel framebuffer out of word-wide memory as an
//   AXI4-Stream, one pixel per beat. Memory words are 32 bit and carry two
//   pixels each: [15:0] is the earlier pixel, [31:16] the later one.
//   A one-cycle 'start' in IDLE latches base_addr and begins a frame.
//
//   Read requests are credit limited. A request is only raised while
//   (outstanding reads + words held in the FIFO) < FIFO_DEPTH. Read data cannot
//   be stalled, so this keeps every response inside the FIFO.
//
//   Handshake semantics (both the read-request and the pixel channel):
//   a transfer happens on a rising edge where valid && ready. Once valid is
//   raised, valid and its payload stay unchanged until that transfer. Valid
//   never depends combinationally on ready.
//
// Ports
//   aclk, resetn      clock, asynchronous active-low reset
//   start, base_addr  frame start pulse and 4-byte aligned framebuffer address
//   busy, frame_done  frame in progress / one-cycle pulse after the last pixel
//   m_mem_ar*         read-request channel (word byte address)
//   m_mem_r*          read-data channel, in order, no backpressure
//   m_axis_t*         pixel stream, tlast on the last pixel of the frame
//   dbg_state         current FSM state (IDLE=0, FETCH=1, DRAIN=2)
module display_frame_streamer #(
  parameter int FRAME_WIDTH  = 480,
  parameter int FRAME_HEIGHT = 320,
  parameter int ADDR_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                  aclk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  m_mem_arvalid,
  input  logic                  m_mem_arready,
  output logic [ADDR_WIDTH-1:0] m_mem_araddr,
  input  logic                  m_mem_rvalid,
  input  logic [31:0]           m_mem_rdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [15:0]           m_axis_tdata,
  output logic [1:0]            dbg_state
);

  localparam int PIXELS = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int WORDS  = PIXELS / 2;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int REQ_W  = $clog2(WORDS + 1);
  localparam int PIX_W  = $clog2(PIXELS);

  localparam logic [REQ_W-1:0] WORDS_C  = REQ_W'(WORDS);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS - 1);
  localparam logic [CNT_W:0]   DEPTH_S  = (CNT_W + 1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            r_state;
  logic                  r_busy;
  logic                  r_frame_done;
  logic                  r_arvalid;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [REQ_W-1:0]      r_req_cnt;
  logic [CNT_W-1:0]      r_outstanding;
  logic [CNT_W-1:0]      r_count;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [31:0]           r_fifo [FIFO_DEPTH];
  logic                  r_half;
  logic [PIX_W-1:0]      r_pix_cnt;

  logic                  w_ar_fire;
  logic                  w_rsp;
  logic                  w_tvalid;
  logic                  w_px_fire;
  logic                  w_pop;
  logic                  w_last;
  logic                  w_last_fire;
  logic [CNT_W-1:0]      w_outstanding_nxt;
  logic [CNT_W-1:0]      w_count_nxt;
  logic [REQ_W-1:0]      w_req_nxt;
  logic [CNT_W:0]        w_credit_used;
  logic                  w_more_req;
  logic [31:0]           w_head;

  assign w_ar_fire   = r_arvalid && m_mem_arready;
  // Data arriving with nothing outstanding is stray and never enters the FIFO.
  assign w_rsp       = m_mem_rvalid && (r_outstanding != '0);
  assign w_tvalid    = (r_count != '0);
  assign w_px_fire   = w_tvalid && m_axis_tready;
  // A word leaves the FIFO only after its high half has been taken.
  assign w_pop       = w_px_fire && r_half;
  assign w_last      = w_tvalid && (r_pix_cnt == PIX_LAST);
  assign w_last_fire = w_px_fire && w_last;
  assign w_head      = r_fifo[r_rd_ptr];

  always_comb begin
    w_outstanding_nxt = r_outstanding;
    if (w_ar_fire && !w_rsp) begin
      w_outstanding_nxt = r_outstanding + CNT_W'(1);
    end else if (!w_ar_fire && w_rsp) begin
      w_outstanding_nxt = r_outstanding - CNT_W'(1);
    end

    w_count_nxt = r_count;
    if (w_rsp && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_rsp && w_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end

    w_req_nxt = r_req_cnt;
    if (w_ar_fire) begin
      w_req_nxt = r_req_cnt + REQ_W'(1);
    end

    // Credit test on next-cycle occupancy: a request raised now is already
    // covered, because occupancy cannot grow again until it is accepted.
    w_credit_used = {1'b0, w_outstanding_nxt} + {1'b0, w_count_nxt};
    w_more_req    = (w_credit_used < DEPTH_S) && (w_req_nxt < WORDS_C);
  end

  // FIFO storage needs no reset: the count gates everything read from it.
  always_ff @(posedge aclk) begin
    if (w_rsp) begin
      r_fifo[r_wr_ptr] <= m_mem_rdata;
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_arvalid     <= 1'b0;
      r_araddr      <= '0;
      r_req_cnt     <= '0;
      r_outstanding <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_half        <= 1'b0;
      r_pix_cnt     <= '0;
    end else begin
      r_frame_done  <= 1'b0;
      r_outstanding <= w_outstanding_nxt;
      r_count       <= w_count_nxt;
      if (w_rsp) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_px_fire) begin
        r_half    <= ~r_half;
        r_pix_cnt <= r_pix_cnt + PIX_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_FETCH;
            r_busy    <= 1'b1;
            r_araddr  <= base_addr;
            r_req_cnt <= '0;
            r_pix_cnt <= '0;
            r_half    <= 1'b0;
            // The FIFO is empty between frames, so the first request can go
            // out immediately.
            r_arvalid <= 1'b1;
          end
        end
        S_FETCH: begin
          if (w_ar_fire) begin
            r_araddr <= r_araddr + ADDR_WIDTH'(4);
          end
          r_req_cnt <= w_req_nxt;
          r_arvalid <= (r_arvalid && !m_mem_arready) || w_more_req;
          if (w_req_nxt == WORDS_C) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_last_fire) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
            r_pix_cnt    <= '0;
            r_half       <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign frame_done    = r_frame_done;
  assign m_mem_arvalid = r_arvalid;
  assign m_mem_araddr  = r_araddr;
  assign m_axis_tvalid = w_tvalid;
  assign m_axis_tlast  = w_last;
  assign m_axis_tdata  = !w_tvalid ? 16'h0000 :
                         (r_half ? w_head[31:16] : w_head[15:0]);
  assign dbg_state     = r_state;

endmodule
